// File: rtl/fifo_traffic_tester_pkg.sv
// Shared definitions for the FIFO traffic generator and its sequence checker,
// so both sides compute the identical data sequence.
package fifo_traffic_tester_pkg;

    localparam int          MODE_INC     = 0;
    localparam int          MODE_LFSR    = 1;
    localparam int          MAX_W        = 64;
    localparam logic [31:0] DEFAULT_TAPS = 32'h8020_0003;

    typedef enum logic [0:0] {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } chk_state_t;

    // Next pattern word; x is right-aligned in MAX_W bits, result is masked to width.
    function automatic logic [MAX_W-1:0] pattern_next(
        input logic [MAX_W-1:0] x,
        input int               width,
        input int               mode,
        input logic [MAX_W-1:0] taps
    );
        logic [MAX_W-1:0] mask;
        logic [MAX_W-1:0] nxt;
        mask = {MAX_W{1'b0}};
        for (int i = 0; i < MAX_W; i++) begin
            mask[i] = (i < width) ? 1'b1 : 1'b0;
        end
        if (mode == MODE_LFSR) begin
            nxt = {x[MAX_W-2:0], ^(x & taps & mask)};
        end else begin
            nxt = x + 64'd1;
        end
        return nxt & mask;
    endfunction

endpackage

// File: rtl/fifo_traffic_tester_seq_checker.sv
// Read-side sequence checker: locks to the first word, then flags every word
// that does not follow its predecessor and resyncs on it.
module seq_checker
    import fifo_traffic_tester_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter int               MODE      = 0,
    parameter logic [WIDTH-1:0] TAPS      = WIDTH'(DEFAULT_TAPS),
    parameter int               ERR_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rd_en,
    input  logic [WIDTH-1:0]     dout,
    input  logic                 chk_clr,
    output logic                 locked,
    output logic                 err,
    output logic                 err_sticky,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic [WIDTH-1:0]     err_exp,
    output logic [WIDTH-1:0]     err_act,
    output logic [31:0]          rx_cnt
);

    localparam logic [ERR_CNT_W-1:0] ERR_MAX = {ERR_CNT_W{1'b1}};
    localparam logic [ERR_CNT_W-1:0] ERR_ONE = {{(ERR_CNT_W-1){1'b0}}, 1'b1};

    chk_state_t           state_r;
    logic                 vld_r;
    logic                 err_r;
    logic                 err_sticky_r;
    logic [ERR_CNT_W-1:0] err_cnt_r;
    logic [WIDTH-1:0]     exp_r;
    logic [WIDTH-1:0]     err_exp_r;
    logic [WIDTH-1:0]     err_act_r;
    logic [31:0]          rx_cnt_r;
    logic [WIDTH-1:0]     nxt_s;

    assign nxt_s = WIDTH'(pattern_next(MAX_W'(dout), WIDTH, MODE, MAX_W'(TAPS)));

    // Lock / compare / resync state machine with error capture and counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= UNLOCKED;
            vld_r        <= 1'b0;
            err_r        <= 1'b0;
            err_sticky_r <= 1'b0;
            err_cnt_r    <= {ERR_CNT_W{1'b0}};
            exp_r        <= {WIDTH{1'b0}};
            err_exp_r    <= {WIDTH{1'b0}};
            err_act_r    <= {WIDTH{1'b0}};
            rx_cnt_r     <= 32'd0;
        end else begin
            vld_r <= rd_en;
            err_r <= 1'b0;
            if (chk_clr) begin
                state_r      <= UNLOCKED;
                err_sticky_r <= 1'b0;
                err_cnt_r    <= {ERR_CNT_W{1'b0}};
                err_exp_r    <= {WIDTH{1'b0}};
                err_act_r    <= {WIDTH{1'b0}};
                rx_cnt_r     <= 32'd0;
            end else if (vld_r) begin
                exp_r <= nxt_s;
                case (state_r)
                    UNLOCKED: state_r <= LOCKED;
                    LOCKED: begin
                        if (dout == exp_r) begin
                            rx_cnt_r <= rx_cnt_r + 32'd1;
                        end else begin
                            err_r <= 1'b1;
                            if (err_cnt_r != ERR_MAX) begin
                                err_cnt_r <= err_cnt_r + ERR_ONE;
                            end
                            // Only the first mismatch since clear is captured.
                            if (!err_sticky_r) begin
                                err_sticky_r <= 1'b1;
                                err_exp_r    <= exp_r;
                                err_act_r    <= dout;
                            end
                        end
                    end
                    default: state_r <= UNLOCKED;
                endcase
            end
        end
    end

    assign locked     = (state_r == LOCKED);
    assign err        = err_r;
    assign err_sticky = err_sticky_r;
    assign err_cnt    = err_cnt_r;
    assign err_exp    = err_exp_r;
    assign err_act    = err_act_r;
    assign rx_cnt     = rx_cnt_r;

endmodule

// File: rtl/fifo_traffic_tester.sv
// FIFO loopback traffic tester: throttled pattern generator on the write side,
// read strobe generation and a sequence checker on the read side.
module fifo_traffic_tester
    import fifo_traffic_tester_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter int               CNT_W     = 11,
    parameter int               AF_LEVEL  = 2032,
    parameter int               MODE      = MODE_INC,
    parameter logic [WIDTH-1:0] TAPS      = WIDTH'(DEFAULT_TAPS),
    parameter logic [WIDTH-1:0] SEED      = WIDTH'(32'd1),
    parameter int               ERR_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 gen_en,
    input  logic [1:0]           gen_duty,
    output logic                 wr_en,
    output logic [WIDTH-1:0]     din,
    input  logic                 wr_full,
    input  logic [CNT_W-1:0]     wr_data_count,
    input  logic                 chk_en,
    input  logic                 rd_empty,
    output logic                 rd_en,
    input  logic [WIDTH-1:0]     dout,
    input  logic                 chk_clr,
    output logic                 locked,
    output logic                 err,
    output logic                 err_sticky,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic [WIDTH-1:0]     err_exp,
    output logic [WIDTH-1:0]     err_act,
    output logic [31:0]          rx_cnt
);

    logic [2:0]       phase_r;
    logic             wr_en_r;
    logic [WIDTH-1:0] din_r;
    logic             opportunity_s;
    logic             below_af_s;
    logic             write_s;

    // Write opportunity every 1/2/4/8 cycles, taken from the free-running phase.
    always_comb begin
        opportunity_s = 1'b1;
        case (gen_duty)
            2'd0:    opportunity_s = 1'b1;
            2'd1:    opportunity_s = (phase_r[0] == 1'b0);
            2'd2:    opportunity_s = (phase_r[1:0] == 2'b00);
            2'd3:    opportunity_s = (phase_r == 3'b000);
            default: opportunity_s = 1'b1;
        endcase
    end

    assign below_af_s = (32'(wr_data_count) < 32'(AF_LEVEL));
    assign write_s    = gen_en & opportunity_s & ~wr_full & below_af_s;

    // Registered write strobe; data advances after each word actually written.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_r <= 3'd0;
            wr_en_r <= 1'b0;
            din_r   <= SEED;
        end else begin
            phase_r <= phase_r + 3'd1;
            wr_en_r <= write_s;
            if (wr_en_r) begin
                din_r <= WIDTH'(pattern_next(MAX_W'(din_r), WIDTH, MODE, MAX_W'(TAPS)));
            end
        end
    end

    assign wr_en = wr_en_r;
    assign din   = din_r;

    // Read strobe stays combinational so it is live even while in reset.
    assign rd_en = chk_en & ~rd_empty;

    seq_checker #(
        .WIDTH     (WIDTH),
        .MODE      (MODE),
        .TAPS      (TAPS),
        .ERR_CNT_W (ERR_CNT_W)
    ) u_checker (
        .clk        (clk),
        .rst        (rst),
        .rd_en      (rd_en),
        .dout       (dout),
        .chk_clr    (chk_clr),
        .locked     (locked),
        .err        (err),
        .err_sticky (err_sticky),
        .err_cnt    (err_cnt),
        .err_exp    (err_exp),
        .err_act    (err_act),
        .rx_cnt     (rx_cnt)
    );

endmodule

// File: tb/tb_fifo_traffic_tester.sv
// Bench for fifo_traffic_tester: an incrementing instance and an LFSR instance,
// each looped back through a queue-based FIFO model and scoreboarded.
module tb_fifo_traffic_tester;

    localparam int          DEPTH  = 16;
    localparam int          AF     = 14;
    localparam logic [31:0] SEED_A = 32'hFFFF_FFFE;
    localparam logic [31:0] SEED_B = 32'h0000_0001;
    localparam logic [31:0] TAPS_B = 32'h8020_0003;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_checks = 0;
    int n_pass   = 0;

    // Instance A: increment pattern, narrow error counter, directed checker access.
    logic        gen_en_a = 1'b0, chk_en_a = 1'b0, chk_clr_a = 1'b0, direct = 1'b0;
    logic [1:0]  duty_a = 2'd0;
    logic        wr_en_a, full_a, empty_a, rd_en_a, locked_a, err_a, sticky_a;
    logic [31:0] din_a, dout_a, err_exp_a, err_act_a, rx_a;
    logic [4:0]  cnt_a;
    logic [3:0]  err_cnt_a;
    logic        d_empty = 1'b1;
    logic [31:0] d_dout = 32'd0;

    // Instance B: LFSR pattern, throttled.
    logic        gen_en_b = 1'b0, chk_en_b = 1'b0, chk_clr_b = 1'b0;
    logic [1:0]  duty_b = 2'd2;
    logic        wr_en_b, full_b, empty_b, rd_en_b, locked_b, err_b, sticky_b;
    logic [31:0] din_b, dout_b, err_exp_b, err_act_b, rx_b;
    logic [4:0]  cnt_b;
    logic [15:0] err_cnt_b;

    // FIFO models
    logic [31:0] fq_a[$];
    logic [31:0] fq_b[$];
    int          f_cnt_a = 0, f_cnt_b = 0, pcnt_a = 0, pcnt_b = 0;
    logic [31:0] f_dout_a = 32'd0, f_dout_b = 32'd0;
    logic        popped_a = 1'b0, popped_b = 1'b0, ovf_a = 1'b0, ovf_b = 1'b0;
    logic        pop_a, pop_b;
    int          ep_a = 0;

    always #5 clk = ~clk;

    assign full_a  = (f_cnt_a >= DEPTH);
    assign cnt_a   = 5'(f_cnt_a);
    assign empty_a = direct ? d_empty : (f_cnt_a == 0);
    assign dout_a  = direct ? d_dout : f_dout_a;
    assign pop_a   = rd_en_a & ~direct;

    assign full_b  = (f_cnt_b >= DEPTH);
    assign cnt_b   = 5'(f_cnt_b);
    assign empty_b = (f_cnt_b == 0);
    assign dout_b  = f_dout_b;
    assign pop_b   = rd_en_b;

    fifo_traffic_tester #(
        .WIDTH(32), .CNT_W(5), .AF_LEVEL(AF), .MODE(0),
        .TAPS(TAPS_B), .SEED(SEED_A), .ERR_CNT_W(4)
    ) u_inc (
        .clk(clk), .rst(rst), .gen_en(gen_en_a), .gen_duty(duty_a),
        .wr_en(wr_en_a), .din(din_a), .wr_full(full_a), .wr_data_count(cnt_a),
        .chk_en(chk_en_a), .rd_empty(empty_a), .rd_en(rd_en_a), .dout(dout_a),
        .chk_clr(chk_clr_a), .locked(locked_a), .err(err_a), .err_sticky(sticky_a),
        .err_cnt(err_cnt_a), .err_exp(err_exp_a), .err_act(err_act_a), .rx_cnt(rx_a)
    );

    fifo_traffic_tester #(
        .WIDTH(32), .CNT_W(5), .AF_LEVEL(AF), .MODE(1),
        .TAPS(TAPS_B), .SEED(SEED_B), .ERR_CNT_W(16)
    ) u_lfsr (
        .clk(clk), .rst(rst), .gen_en(gen_en_b), .gen_duty(duty_b),
        .wr_en(wr_en_b), .din(din_b), .wr_full(full_b), .wr_data_count(cnt_b),
        .chk_en(chk_en_b), .rd_empty(empty_b), .rd_en(rd_en_b), .dout(dout_b),
        .chk_clr(chk_clr_b), .locked(locked_b), .err(err_b), .err_sticky(sticky_b),
        .err_cnt(err_cnt_b), .err_exp(err_exp_b), .err_act(err_act_b), .rx_cnt(rx_b)
    );

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] lfsr_step(input logic [31:0] x);
        return {x[30:0], ^(x & TAPS_B)};
    endfunction

    // FIFO model A (shares the tester reset)
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            fq_a.delete();
            f_cnt_a  <= 0;
            pcnt_a   <= 0;
            popped_a <= 1'b0;
        end else begin
            if (wr_en_a && f_cnt_a >= DEPTH) ovf_a <= 1'b1;
            if (wr_en_a && f_cnt_a < DEPTH) fq_a.push_back(din_a);
            if (pop_a) f_dout_a <= fq_a.pop_front();
            popped_a <= pop_a;
            pcnt_a   <= pcnt_a + (pop_a ? 1 : 0);
            f_cnt_a  <= f_cnt_a + ((wr_en_a && f_cnt_a < DEPTH) ? 1 : 0) - (pop_a ? 1 : 0);
        end
    end

    // FIFO model B
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            fq_b.delete();
            f_cnt_b  <= 0;
            pcnt_b   <= 0;
            popped_b <= 1'b0;
        end else begin
            if (wr_en_b && f_cnt_b >= DEPTH) ovf_b <= 1'b1;
            if (wr_en_b && f_cnt_b < DEPTH) fq_b.push_back(din_b);
            if (pop_b) f_dout_b <= fq_b.pop_front();
            popped_b <= pop_b;
            pcnt_b   <= pcnt_b + (pop_b ? 1 : 0);
            f_cnt_b  <= f_cnt_b + ((wr_en_b && f_cnt_b < DEPTH) ? 1 : 0) - (pop_b ? 1 : 0);
        end
    end

    // Scoreboard A: words out of the FIFO follow SEED_A + n; back-off honoured.
    initial begin : mon_a
        logic [31:0] exp_m;
        int          last_cnt;
        exp_m    = SEED_A;
        last_cnt = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_m = SEED_A;
            end else begin
                if (popped_a) begin
                    check_eq("seq_a", f_dout_a, exp_m);
                    exp_m = exp_m + 32'd1;
                end
                if (wr_en_a) check_eq("af_backoff_a", last_cnt < AF, 64'd1);
            end
            if (err_a) ep_a++;
            last_cnt = f_cnt_a;
        end
    end

    // Scoreboard B: LFSR sequence from SEED_B; writes at least 4 cycles apart.
    initial begin : mon_b
        logic [31:0] exp_m;
        int          gap;
        exp_m = SEED_B;
        gap   = 8;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_m = SEED_B;
                gap   = 8;
            end else begin
                gap++;
                if (popped_b) begin
                    check_eq("seq_b", f_dout_b, exp_m);
                    exp_m = lfsr_step(exp_m);
                end
                if (wr_en_b) begin
                    check_eq("duty_gap_b", gap >= 4, 64'd1);
                    gap = 0;
                end
            end
        end
    end

    // One word into checker A: rd_en for a cycle, then dout valid the cycle after.
    task automatic push_word(input logic [31:0] v);
        @(negedge clk);
        d_empty = 1'b0;
        @(negedge clk);
        d_empty = 1'b1;
        d_dout  = v;
    endtask

    task automatic settle();
        repeat (2) @(negedge clk);
    endtask

    task automatic clear_a();
        @(negedge clk);
        chk_clr_a = 1'b1;
        @(negedge clk);
        chk_clr_a = 1'b0;
    endtask

    initial begin : main
        int ep0;

        repeat (3) @(negedge clk);
        check_eq("rst_wr_en_a", wr_en_a, 64'd0);
        check_eq("rst_din_a", din_a, SEED_A);
        check_eq("rst_locked_a", locked_a, 64'd0);
        check_eq("rst_err_cnt_a", err_cnt_a, 64'd0);
        check_eq("rst_rx_a", rx_a, 64'd0);
        check_eq("rst_din_b", din_b, SEED_B);
        rst = 1'b0;

        // Randomized loopback on both instances.
        gen_en_a = 1'b1;
        gen_en_b = 1'b1;
        begin : loopback
            int cyc;
            cyc = 0;
            while ((pcnt_a < 1000 || pcnt_b < 500) && cyc < 20000) begin
                @(negedge clk);
                chk_en_a = (pcnt_a < 1000) && ($urandom_range(0, 1) == 1);
                chk_en_b = (pcnt_b < 500) && ($urandom_range(0, 1) == 1);
                cyc++;
            end
            chk_en_a = 1'b0;
            chk_en_b = 1'b0;
            check_eq("loop_budget", cyc < 20000, 64'd1);
        end
        repeat (3) @(negedge clk);
        check_eq("inc_rx", rx_a, 64'd999);
        check_eq("inc_err_cnt", err_cnt_a, 64'd0);
        check_eq("inc_sticky", sticky_a, 64'd0);
        check_eq("inc_locked", locked_a, 64'd1);
        check_eq("inc_no_overflow", ovf_a, 64'd0);
        check_eq("lfsr_rx", rx_b, 64'd499);
        check_eq("lfsr_err_cnt", err_cnt_b, 64'd0);
        check_eq("lfsr_locked", locked_b, 64'd1);
        check_eq("lfsr_no_overflow", ovf_b, 64'd0);

        // Directed checker traffic on A; B keeps streaming.
        gen_en_a = 1'b0;
        chk_en_b = 1'b1;
        direct   = 1'b1;
        chk_en_a = 1'b1;
        clear_a();
        check_eq("clr_rx", rx_a, 64'd0);
        check_eq("clr_locked", locked_a, 64'd0);

        ep0 = ep_a;
        push_word(32'd1); push_word(32'd2); push_word(32'd3); push_word(32'd4);
        push_word(32'd6); push_word(32'd7); push_word(32'd8);
        settle();
        check_eq("drop_pulses", ep_a - ep0, 64'd1);
        check_eq("drop_err_cnt", err_cnt_a, 64'd1);
        check_eq("drop_sticky", sticky_a, 64'd1);
        check_eq("drop_err_exp", err_exp_a, 64'd5);
        check_eq("drop_err_act", err_act_a, 64'd6);
        check_eq("drop_rx", rx_a, 64'd5);

        clear_a();
        push_word(32'hFFFF_FFFE); push_word(32'hFFFF_FFFF);
        push_word(32'h0000_0000); push_word(32'h0000_0001);
        settle();
        check_eq("wrap_err_cnt", err_cnt_a, 64'd0);
        check_eq("wrap_rx", rx_a, 64'd3);

        clear_a();
        ep0 = ep_a;
        push_word(32'd0);
        for (int i = 1; i <= 20; i++) push_word(32'(i * 10));
        settle();
        check_eq("sat_err_cnt", err_cnt_a, 64'd15);
        check_eq("sat_sticky", sticky_a, 64'd1);
        check_eq("sat_err_exp", err_exp_a, 64'd1);
        check_eq("sat_err_act", err_act_a, 64'd10);
        check_eq("sat_pulses", ep_a - ep0, 64'd20);

        // Clear coinciding with a (mismatching) valid word.
        clear_a();
        push_word(32'd100); push_word(32'd101);
        settle();
        check_eq("pre_clr_rx", rx_a, 64'd1);
        @(negedge clk);
        d_empty = 1'b0;
        @(negedge clk);
        d_empty   = 1'b1;
        d_dout    = 32'd555;
        chk_clr_a = 1'b1;
        @(negedge clk);
        chk_clr_a = 1'b0;
        settle();
        check_eq("clrword_locked", locked_a, 64'd0);
        check_eq("clrword_err_cnt", err_cnt_a, 64'd0);
        check_eq("clrword_rx", rx_a, 64'd0);
        push_word(32'd200);
        settle();
        check_eq("relock_locked", locked_a, 64'd1);
        check_eq("relock_rx", rx_a, 64'd0);
        push_word(32'd201);
        push_word(32'd300);
        settle();
        check_eq("relock_rx2", rx_a, 64'd1);
        check_eq("relock_err_cnt", err_cnt_a, 64'd1);

        // Asynchronous reset mid-burst.
        d_empty = 1'b0;
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check_eq("arst_wr_en_a", wr_en_a, 64'd0);
        check_eq("arst_din_a", din_a, SEED_A);
        check_eq("arst_locked_a", locked_a, 64'd0);
        check_eq("arst_err_a", err_a, 64'd0);
        check_eq("arst_sticky_a", sticky_a, 64'd0);
        check_eq("arst_err_cnt_a", err_cnt_a, 64'd0);
        check_eq("arst_err_exp_a", err_exp_a, 64'd0);
        check_eq("arst_err_act_a", err_act_a, 64'd0);
        check_eq("arst_rx_a", rx_a, 64'd0);
        check_eq("arst_rd_en_a", rd_en_a, 64'd1);
        check_eq("arst_wr_en_b", wr_en_b, 64'd0);
        check_eq("arst_din_b", din_b, SEED_B);
        check_eq("arst_locked_b", locked_b, 64'd0);
        check_eq("arst_rx_b", rx_b, 64'd0);
        d_empty = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("hold_din_b", din_b, SEED_B);
        rst = 1'b0;

        repeat (200) @(negedge clk);
        chk_en_b = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("post_rst_some_words", pcnt_b > 1, 64'd1);
        check_eq("post_rst_locked_b", locked_b, 64'd1);
        check_eq("post_rst_err_cnt_b", err_cnt_b, 64'd0);
        check_eq("post_rst_rx_b", rx_b, 64'(pcnt_b - 1));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
